sram_bank_arbiter: RTL and testbench

Round-robin arbiter that shares one `sram_controler` bank between up to `NUM_REQ` pipeline-stage requesters. In each parallel lane, pipe stages 2/3/5/6 all read and write the same scratch bank. The arbiter grants at most one request per cycle and registers the selected command onto the bank port. It routes read data back to the issuing requester after a fixed latency. A bounded lock lets one requester issue back-to-back beats, for example a multi-word operand fetch, without interleaving.

---
 rtl/sram_bank_arbiter.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sram_bank_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_arbiter.sv
// -----------------------------------------------------------------------------
// sram_bank_arbiter
//
// Shares a single scratch SRAM bank between NUM_REQ pipeline-stage
// requesters. At most one request is granted per cycle. Grants rotate
// round-robin. A requester may hold a bounded lock so that it can issue
// back-to-back beats without other requesters interleaving. The granted
// command is registered onto the bank port. Read data is steered back to
// the issuing requester two cycles after the accept.
//
// Handshake: a requester raises req_valid_i[i] and holds addr/we/wdata/lock
// stable until it is accepted. An accept happens in any cycle where
// req_valid_i[i] && req_ready_o[i]. req_ready_o is combinational and is
// one-hot or zero. Responses have no backpressure. rsp_valid_o[i] is a
// one-cycle pulse that qualifies rsp_rdata_o.
//
// Ports
//   CLK_i, RST_i        clock, synchronous active-high reset
//   req_valid_i         per-requester request valid
//   req_ready_o         per-requester grant (combinational, one-hot or zero)
//   req_we_i            per-requester write enable (1 = write)
//   req_lock_i          per-requester "keep grant on next beat"
//   req_addr_i          NUM_REQ x ADDR_W packed word addresses
//   req_wdata_i         NUM_REQ x LANES*WIDTH packed write data
//   rsp_valid_o         per-requester read response pulse
//   rsp_rdata_o         shared read data, qualified by rsp_valid_o
//   sram_en_o/we_o/addr_o/wdata_o   registered bank command
//   sram_rdata_i        bank read data, one cycle after a read strobe
//   dbg_rr_ptr_o        current round-robin priority index
//   dbg_lock_valid_o    lock state (1 = a requester holds the lock)
//   dbg_lock_own_o      current lock owner
//   dbg_lock_cnt_o      beats granted under the current lock
// -----------------------------------------------------------------------------
module sram_bank_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 8,
    parameter int WIDTH    = 16,
    parameter int LANES    = 16,
    parameter int LOCK_MAX = 8,
    localparam int DATA_W  = LANES * WIDTH,
    localparam int IDX_W   = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(LOCK_MAX + 1)
) (
    input  logic                      CLK_i,
    input  logic                      RST_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ-1:0]        req_lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      sram_en_o,
    output logic                      sram_we_o,
    output logic [ADDR_W-1:0]         sram_addr_o,
    output logic [DATA_W-1:0]         sram_wdata_o,
    input  logic [DATA_W-1:0]         sram_rdata_i,
    output logic [IDX_W-1:0]          dbg_rr_ptr_o,
    output logic                      dbg_lock_valid_o,
    output logic [IDX_W-1:0]          dbg_lock_own_o,
    output logic [CNT_W-1:0]          dbg_lock_cnt_o
);

    // One extra bit so rr_ptr + offset never overflows before the wrap.
    localparam logic [IDX_W:0]   NUM_REQ_W  = (IDX_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    typedef enum logic {
        LK_FREE = 1'b0,
        LK_HELD = 1'b1
    } lock_state_e;

    // Lock / priority state
    lock_state_e      lock_state_q, lock_state_d;
    logic [IDX_W-1:0] lock_own_q, lock_own_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // Registered bank command
    logic              sram_en_q;
    logic              sram_we_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;

    // Read response pipeline
    logic             rsp_s1_vld_q, rsp_s2_vld_q;
    logic [IDX_W-1:0] rsp_s1_id_q, rsp_s2_id_q;

    // Grant selection
    logic             lock_hold;
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   scan_idx;
    logic             accept;

    // Selected requester's command
    logic              sel_we;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Next-state helpers
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic [IDX_W:0]   rr_next;

    // -------------------------------------------------------------------------
    // Grant selection
    // -------------------------------------------------------------------------
    always_comb begin : grant_sel
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        // A lock only holds while its owner keeps valid high. Otherwise the
        // lock releases and normal arbitration runs in this same cycle.
        lock_hold = (lock_state_q == LK_HELD) && req_valid_i[lock_own_q];
        if (lock_hold) begin
            grant_vld = 1'b1;
            grant_idx = lock_own_q;
        end else begin
            // Scan from the farthest offset down to offset 0. The last
            // match wins, so the requester closest to rr_ptr gets the grant.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                scan_idx = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
                if (scan_idx >= NUM_REQ_W) begin
                    scan_idx = scan_idx - NUM_REQ_W;
                end
                if (req_valid_i[scan_idx[IDX_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx[IDX_W-1:0];
                end
            end
        end
        if (RST_i) begin
            grant_vld = 1'b0;
        end
    end

    // A grant only goes to a valid requester, so grant == accept.
    assign accept = grant_vld;

    always_comb begin : ready_dec
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = grant_vld && (grant_idx == IDX_W'(i));
        end
    end

    always_comb begin : cmd_mux
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_we    = req_we_i[i];
                sel_lock  = req_lock_i[i];
                sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Lock FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin : lock_next
        lock_state_d = lock_state_q;
        lock_own_d   = lock_own_q;
        lock_cnt_d   = lock_cnt_q;
        rr_ptr_d     = rr_ptr_q;

        // A released lock contributes no beats to a new lock.
        cnt_base = lock_hold ? lock_cnt_q : '0;
        cnt_next = cnt_base + CNT_W'(1);

        rr_next = {1'b0, grant_idx} + (IDX_W + 1)'(1);
        if (rr_next == NUM_REQ_W) begin
            rr_next = '0;
        end

        if (!lock_hold) begin
            lock_state_d = LK_FREE;
            lock_cnt_d   = '0;
        end

        if (accept) begin
            if (sel_lock && (cnt_next < LOCK_MAX_C)) begin
                // Keep the grant and leave the round-robin pointer alone.
                lock_state_d = LK_HELD;
                lock_own_d   = grant_idx;
                lock_cnt_d   = cnt_next;
            end else begin
                // Normal grant or forced release at LOCK_MAX beats.
                lock_state_d = LK_FREE;
                lock_cnt_d   = '0;
                rr_ptr_d     = rr_next[IDX_W-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Lock FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_i) begin : lock_regs
        if (RST_i) begin
            lock_state_q <= LK_FREE;
            lock_own_q   <= '0;
            lock_cnt_q   <= '0;
            rr_ptr_q     <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_own_q   <= lock_own_d;
            lock_cnt_q   <= lock_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Bank command register and response pipeline
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_i) begin : datapath_regs
        if (RST_i) begin
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            rsp_s1_vld_q <= 1'b0;
            rsp_s1_id_q  <= '0;
            rsp_s2_vld_q <= 1'b0;
            rsp_s2_id_q  <= '0;
        end else begin
            sram_en_q <= accept;
            // Without an accept the command fields keep their last values.
            if (accept) begin
                sram_we_q    <= sel_we;
                sram_addr_q  <= sel_addr;
                sram_wdata_q <= sel_wdata;
            end
            // Stage 1 lines up with the bank strobe. Stage 2 lines up with
            // the bank's read data one cycle later.
            rsp_s1_vld_q <= accept && !sel_we;
            rsp_s1_id_q  <= grant_idx;
            rsp_s2_vld_q <= rsp_s1_vld_q;
            rsp_s2_id_q  <= rsp_s1_id_q;
        end
    end

    assign sram_en_o    = sram_en_q;
    assign sram_we_o    = sram_we_q;
    assign sram_addr_o  = sram_addr_q;
    assign sram_wdata_o = sram_wdata_q;

    always_comb begin : rsp_dec
        rsp_valid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_o[i] = rsp_s2_vld_q && (rsp_s2_id_q == IDX_W'(i));
        end
    end

    assign rsp_rdata_o = sram_rdata_i;

    assign dbg_rr_ptr_o     = rr_ptr_q;
    assign dbg_lock_valid_o = (lock_state_q == LK_HELD);
    assign dbg_lock_own_o   = lock_own_q;
    assign dbg_lock_cnt_o   = lock_cnt_q;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sram_bank_arbiter. A behavioural bank model sits
// on the SRAM port. A reference model predicts grants, and per-cycle queues
// hold the expected bank commands and read responses.
// -----------------------------------------------------------------------------
module tb_sram_bank_arbiter;
  localparam int N        = 4;
  localparam int AW       = 8;
  localparam int W        = 16;
  localparam int L        = 16;
  localparam int DW       = L * W;
  localparam int LOCK_MAX = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut signals
  logic [N-1:0]    req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, sram_wdata, sram_rdata;
  logic            sram_en, sram_we;
  logic [AW-1:0]   sram_addr;
  logic [1:0]      dbg_rr, dbg_own;
  logic            dbg_lv;
  logic [3:0]      dbg_cnt;

  sram_bank_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .WIDTH(W), .LANES(L), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .CLK_i(clk), .RST_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_lock_i(req_lock), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
    .dbg_rr_ptr_o(dbg_rr), .dbg_lock_valid_o(dbg_lv),
    .dbg_lock_own_o(dbg_own), .dbg_lock_cnt_o(dbg_cnt)
  );

  // initial bank contents as a function of the address
  function automatic logic [DW-1:0] init_word(input int a);
    logic [DW-1:0] w;
    for (int l = 0; l < L; l++) w[l*W +: W] = W'(a * 37 + l * 101 + 4660);
    return w;
  endfunction

  // behavioural bank: read data one cycle after a read strobe
  logic [DW-1:0] bank_mem[256];
  bit            bank_wr[256];
  always @(posedge clk) begin
    if (sram_en === 1'b1) begin
      if (sram_we) begin
        bank_mem[sram_addr] <= sram_wdata;
        bank_wr[sram_addr]  <= 1'b1;
      end else begin
        sram_rdata <= bank_wr[sram_addr] ? bank_mem[sram_addr] : init_word(int'(sram_addr));
      end
    end
  end

  // reference model
  int            m_rr, m_own, m_beats;
  logic [DW-1:0] ref_mem[256];
  bit            ref_wr[256];

  typedef struct {int due; logic we; logic [AW-1:0] addr; logic [DW-1:0] wd;} cmd_t;
  typedef struct {int due; int id; logic [DW-1:0] data;} rsp_t;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  logic          last_we;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wd;
  bit            mon_en = 1'b0;

  int total = 0;
  int bad   = 0;

  function automatic int model_pick(input logic [N-1:0] v);
    if (m_own >= 0 && v[m_own]) return m_own;
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_word(int'(a));
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int c = 0; c < DW / 32; c++) w[c*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic clear_model();
    m_rr = 0; m_own = -1; m_beats = 0;
    cmd_q.delete(); rsp_q.delete();
    last_we = 1'b0; last_addr = '0; last_wd = '0;
  endtask

  // driver: called at a negedge, returns at the next negedge
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] we, input logic [N-1:0] lk,
                       input logic [N*AW-1:0] ad, input logic [N*DW-1:0] wd,
                       output int got_g, output int exp_g);
    logic [AW-1:0] a;
    req_valid = v; req_we = we; req_lock = lk; req_addr = ad; req_wdata = wd;
    #1;
    exp_g = model_pick(v);
    got_g = -1;
    for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) got_g = (got_g == -1) ? i : -2;
    @(posedge clk); #1;
    if (m_own >= 0 && !v[m_own]) begin m_own = -1; m_beats = 0; end
    if (exp_g >= 0) begin
      a = ad[exp_g*AW +: AW];
      cmd_q.push_back('{cyc, we[exp_g], a, wd[exp_g*DW +: DW]});
      if (we[exp_g]) begin
        ref_mem[a] = wd[exp_g*DW +: DW];
        ref_wr[a]  = 1'b1;
      end else begin
        rsp_q.push_back('{cyc + 1, exp_g, ref_read(a)});
      end
      if (lk[exp_g] && m_beats + 1 < LOCK_MAX) begin
        m_own = exp_g; m_beats++;
      end else begin
        m_own = -1; m_beats = 0; m_rr = (exp_g + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = '0; req_we = '0; req_lock = '0;
    repeat (2) begin @(posedge clk); #1; clear_model(); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard: bank command and response checked every cycle
  task automatic monitor();
    cmd_t          c;
    rsp_t          r;
    logic [N-1:0]  ev;
    forever begin
      @(posedge clk); #3;
      if (mon_en) begin
        total++;
        if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
          c = cmd_q.pop_front();
          if (sram_en !== 1'b1 || sram_we !== c.we || sram_addr !== c.addr || sram_wdata !== c.wd) begin
            bad++;
            $display("FAIL sram_cmd cyc=%0d got en=%b we=%b addr=%h want en=1 we=%b addr=%h", cyc, sram_en, sram_we, sram_addr, c.we, c.addr);
          end
          last_we = c.we; last_addr = c.addr; last_wd = c.wd;
        end else if (sram_en !== 1'b0 || sram_we !== last_we || sram_addr !== last_addr || sram_wdata !== last_wd) begin
          bad++;
          $display("FAIL sram_idle cyc=%0d got en=%b we=%b addr=%h want en=0 we=%b addr=%h", cyc, sram_en, sram_we, sram_addr, last_we, last_addr);
        end
        total++;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
          r = rsp_q.pop_front();
          ev = '0; ev[r.id] = 1'b1;
          if (rsp_valid !== ev || rsp_rdata !== r.data) begin
            bad++;
            $display("FAIL rsp cyc=%0d got valid=%b want valid=%b data_ok=%0d", cyc, rsp_valid, ev, rsp_rdata === r.data);
          end
        end else if (rsp_valid !== '0) begin
          bad++;
          $display("FAIL rsp_idle cyc=%0d got valid=%b want 0000", cyc, rsp_valid);
        end
      end
    end
  endtask

  logic [N*AW-1:0] ad;
  logic [N*DW-1:0] wd;
  int got, exp_g;

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    #1;
    total++;
    if (req_ready !== '0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    repeat (2) begin @(posedge clk); #1; clear_model(); end
    @(negedge clk);
    total++;
    if (sram_en !== 1'b0 || sram_we !== 1'b0 || sram_addr !== '0 || sram_wdata !== '0) begin
      bad++; $display("FAIL reset_sram got en=%b we=%b addr=%h want all 0", sram_en, sram_we, sram_addr);
    end
    total++;
    if (rsp_valid !== '0 || dbg_rr !== 2'd0 || dbg_lv !== 1'b0 || dbg_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_state got rsp=%b rr=%0d lv=%b cnt=%0d want 0", rsp_valid, dbg_rr, dbg_lv, dbg_cnt);
    end
    req_valid = '0;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < N; i++) ad[i*AW +: AW] = AW'(8'h10 + i);
    wd = '0;
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, 4'h0, 4'h0, ad, wd, got, exp_g);
      total++;
      if (got !== seq[k]) begin bad++; $display("FAIL rr_grant beat=%0d got=%0d want=%0d", k, got, seq[k]); end
    end
    drive(4'h0, 4'h0, 4'h0, ad, wd, got, exp_g);
    total++;
    if (got !== -1) begin bad++; $display("FAIL rr_idle got=%0d want=-1", got); end
    repeat (2) drive(4'h0, 4'h0, 4'h0, ad, wd, got, exp_g);
  endtask

  task automatic test_rr_pointer();
    apply_reset();
    for (int i = 0; i < N; i++) ad[i*AW +: AW] = AW'(8'h20 + i);
    drive(4'b0100, 4'h0, 4'h0, ad, wd, got, exp_g);
    total++;
    if (got !== 2 || dbg_rr !== 2'd3) begin bad++; $display("FAIL ptr_single got=%0d rr=%0d want=2 rr=3", got, dbg_rr); end
    drive(4'b1010, 4'h0, 4'h0, ad, wd, got, exp_g);
    total++;
    if (got !== 3) begin bad++; $display("FAIL ptr_pair got=%0d want=3", got); end
    drive(4'b0010, 4'h0, 4'h0, ad, wd, got, exp_g);
    total++;
    if (got !== 1) begin bad++; $display("FAIL ptr_next got=%0d want=1", got); end
    repeat (3) drive(4'h0, 4'h0, 4'h0, ad, wd, got, exp_g);
  endtask

  task automatic test_lock_max();
    int seq[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 0};
    apply_reset();
    for (int i = 0; i < N; i++) ad[i*AW +: AW] = AW'(8'h30 + i);
    drive(4'b0001, 4'h0, 4'h0, ad, wd, got, exp_g);   // moves priority to requester 1
    for (int k = 0; k < 10; k++) begin
      drive(4'b0111, 4'h0, 4'b0010, ad, wd, got, exp_g);
      total++;
      if (got !== seq[k]) begin bad++; $display("FAIL lock_grant beat=%0d got=%0d want=%0d", k, got, seq[k]); end
      if (k == 6 || k == 7) begin
        total++;
        if (dbg_cnt !== ((k == 6) ? 4'd7 : 4'd0)) begin
          bad++; $display("FAIL lock_cnt beat=%0d got=%0d want=%0d", k, dbg_cnt, (k == 6) ? 7 : 0);
        end
      end
    end
    repeat (3) drive(4'h0, 4'h0, 4'h0, ad, wd, got, exp_g);
  endtask

  task automatic test_lock_drop();
    apply_reset();
    for (int i = 0; i < N; i++) ad[i*AW +: AW] = AW'(8'h40 + i);
    for (int k = 0; k < 3; k++) begin
      drive(4'b1010, 4'h0, 4'b0010, ad, wd, got, exp_g);
      total++;
      if (got !== 1) begin bad++; $display("FAIL drop_owner beat=%0d got=%0d want=1", k, got); end
    end
    total++;
    if (dbg_lv !== 1'b1 || dbg_cnt !== 4'd3) begin bad++; $display("FAIL drop_held got lv=%b cnt=%0d want lv=1 cnt=3", dbg_lv, dbg_cnt); end
    drive(4'b1000, 4'h0, 4'b0010, ad, wd, got, exp_g);
    total++;
    if (got !== 3) begin bad++; $display("FAIL drop_switch got=%0d want=3", got); end
    total++;
    if (dbg_lv !== 1'b0 || dbg_cnt !== 4'd0) begin bad++; $display("FAIL drop_release got lv=%b cnt=%0d want lv=0 cnt=0", dbg_lv, dbg_cnt); end
    repeat (3) drive(4'h0, 4'h0, 4'h0, ad, wd, got, exp_g);
  endtask

  task automatic test_write_read();
    logic [DW-1:0] pat;
    pat = {L{16'hABCD}};
    apply_reset();
    ad = '0; wd = '0;
    ad[0*AW +: AW] = 8'd5; ad[3*AW +: AW] = 8'd5;
    wd[0*DW +: DW] = pat;
    drive(4'b0001, 4'b0001, 4'h0, ad, wd, got, exp_g);
    total++;
    if (got !== 0 || sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 8'd5 || sram_wdata !== pat) begin
      bad++; $display("FAIL wr_cmd got g=%0d en=%b we=%b addr=%h want g=0 en=1 we=1 addr=05", got, sram_en, sram_we, sram_addr);
    end
    drive(4'b1000, 4'b0000, 4'h0, ad, wd, got, exp_g);
    total++;
    if (got !== 3 || rsp_valid !== '0) begin bad++; $display("FAIL rd_grant got g=%0d rsp=%b want g=3 rsp=0000", got, rsp_valid); end
    drive(4'h0, 4'h0, 4'h0, ad, wd, got, exp_g);
    total++;
    if (rsp_valid !== 4'b1000 || rsp_rdata !== pat) begin
      bad++; $display("FAIL rd_rsp got valid=%b data=%h want valid=1000 data=%h", rsp_valid, rsp_rdata[15:0], pat[15:0]);
    end
    drive(4'h0, 4'h0, 4'h0, ad, wd, got, exp_g);
    total++;
    if (rsp_valid !== '0) begin bad++; $display("FAIL rd_after got=%b want=0000", rsp_valid); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    for (int i = 0; i < N; i++) ad[i*AW +: AW] = AW'(8'h50 + i);
    drive(4'b0010, 4'h0, 4'h0, ad, wd, got, exp_g);
    total++;
    if (got !== 1) begin bad++; $display("FAIL mid_accept got=%0d want=1", got); end
    rst = 1'b1; req_valid = '1;
    #1;
    total++;
    if (req_ready !== '0) begin bad++; $display("FAIL mid_ready got=%b want=0000", req_ready); end
    @(posedge clk); #1; clear_model();
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
    total++;
    if (rsp_valid !== '0 || sram_en !== 1'b0 || sram_we !== 1'b0 || sram_addr !== '0 || sram_wdata !== '0) begin
      bad++; $display("FAIL mid_outputs got rsp=%b en=%b we=%b addr=%h want all 0", rsp_valid, sram_en, sram_we, sram_addr);
    end
    drive(4'hF, 4'h0, 4'h0, ad, wd, got, exp_g);
    total++;
    if (got !== 0 || rsp_valid !== '0) begin bad++; $display("FAIL mid_restart got g=%0d rsp=%b want g=0 rsp=0000", got, rsp_valid); end
    repeat (3) drive(4'h0, 4'h0, 4'h0, ad, wd, got, exp_g);
  endtask

  task automatic test_random();
    bit            pend[N];
    logic [N-1:0]  v, we, lk;
    apply_reset();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    we = '0; lk = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(15) == 0) pend[i] = 1'b0;   // withdraw
        else if (!pend[i] && $urandom_range(1) == 1) begin
          pend[i] = 1'b1;
          we[i] = $urandom_range(1);
          lk[i] = ($urandom_range(2) == 0);
          ad[i*AW +: AW] = AW'($urandom_range(15));
          wd[i*DW +: DW] = rand_word();
        end
      end
      for (int i = 0; i < N; i++) v[i] = pend[i];
      drive(v, we, lk, ad, wd, got, exp_g);
      total++;
      if (got !== exp_g) begin bad++; $display("FAIL rand_grant t=%0d valid=%b got=%0d want=%0d", t, v, got, exp_g); end
      if (exp_g >= 0) pend[exp_g] = 1'b0;
    end
    repeat (3) drive(4'h0, 4'h0, 4'h0, ad, wd, got, exp_g);
    total++;
    if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
      bad++; $display("FAIL drain got cmd=%0d rsp=%0d pending want 0", cmd_q.size(), rsp_q.size());
    end
  endtask

  initial begin
    clear_model();
    ad = '0; wd = '0;
    for (int a = 0; a < 256; a++) ref_wr[a] = 1'b0;
    fork
      monitor();
    join_none
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_rr_pointer();
    test_lock_max();
    test_lock_drop();
    test_write_read();
    test_reset_midflight();
    test_random();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
